// File: rtl/avalon_mem_arbiter_pkg.sv
// Shared types and constants for the two-port Avalon memory arbiter.
package avalon_mem_arbiter_pkg;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_GRANT_I = 2'd1,
      ST_GRANT_D = 2'd2
   } arb_state_t;

   typedef enum logic {
      PORT_I = 1'b0,
      PORT_D = 1'b1
   } arb_port_t;

   localparam int DEFAULT_TIMEOUT = 255;

   // Width needed to hold the value 'limit' itself (the counter saturates there).
   function automatic int ctr_width(input int limit);
      return (limit < 2) ? 1 : $clog2(limit + 1);
   endfunction

endpackage

// File: rtl/avalon_mem_arbiter_timeout_ctr.sv
// Saturating stall counter: counts enabled cycles, clear wins over enable,
// expired is high once the count sits at TIMEOUT.
module arb_timeout_ctr
   import avalon_mem_arbiter_pkg::*;
#(
   parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
   input  logic clk,
   input  logic reset,
   input  logic enable,
   input  logic clear,
   output logic expired
);

   localparam int W = ctr_width(TIMEOUT);
   localparam logic [W-1:0] LIMIT = W'(TIMEOUT);

   logic [W-1:0] count_q, count_d;

   always_comb begin
      count_d = count_q;
      if (clear) begin
         count_d = '0;
      end else if (enable && (count_q != LIMIT)) begin
         count_d = count_q + W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   assign expired = (count_q == LIMIT);

endmodule

// File: rtl/avalon_mem_arbiter.sv
// Arbitrates an instruction-fetch port and a data port onto one Avalon master,
// alternating between them under contention and aborting grants that stall too long.
module avalon_mem_arbiter
   import avalon_mem_arbiter_pkg::*;
#(
   parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [31:0] i_address,
   input  logic        i_read,
   output logic        i_waitrequest,
   output logic [31:0] i_readdata,
   input  logic [31:0] d_address,
   input  logic        d_read,
   input  logic        d_write,
   input  logic [31:0] d_writedata,
   input  logic [3:0]  d_byteenable,
   output logic        d_waitrequest,
   output logic [31:0] d_readdata,
   output logic [31:0] m_address,
   output logic        m_read,
   output logic        m_write,
   output logic [31:0] m_writedata,
   output logic [3:0]  m_byteenable,
   input  logic        m_waitrequest,
   input  logic [31:0] m_readdata,
   output logic        timeout_err
);

   arb_state_t state_q, state_d;
   arb_port_t  last_q, last_d;
   logic       timeout_err_q, timeout_err_d;

   logic i_req, d_req, d_rd;
   logic granted, own_req, other_req;
   logic complete, abort, expired;
   logic ctr_enable, ctr_clear;

   assign i_req = i_read;
   assign d_req = d_read | d_write;
   assign d_rd  = d_read & ~d_write;

   always_comb begin
      granted   = 1'b0;
      own_req   = 1'b0;
      other_req = 1'b0;
      case (state_q)
         ST_GRANT_I: begin
            granted   = 1'b1;
            own_req   = i_req;
            other_req = d_req;
         end
         ST_GRANT_D: begin
            granted   = 1'b1;
            own_req   = d_req;
            other_req = i_req;
         end
         default: ;
      endcase
   end

   // An expired counter takes precedence: the grant is aborted, never completed.
   assign abort    = granted & own_req & expired;
   assign complete = granted & own_req & ~m_waitrequest & ~expired;

   assign ctr_enable = granted & own_req & m_waitrequest;
   assign ctr_clear  = ~granted | ~own_req | complete | abort;

   arb_timeout_ctr #(
      .TIMEOUT (TIMEOUT)
   ) u_timeout_ctr (
      .clk     (clk),
      .reset   (reset),
      .enable  (ctr_enable),
      .clear   (ctr_clear),
      .expired (expired)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q       <= ST_IDLE;
         last_q        <= PORT_I;
         timeout_err_q <= 1'b0;
      end else begin
         state_q       <= state_d;
         last_q        <= last_d;
         timeout_err_q <= timeout_err_d;
      end
   end

   always_comb begin
      state_d       = state_q;
      last_d        = last_q;
      timeout_err_d = timeout_err_q | abort;
      case (state_q)
         ST_IDLE: begin
            if (i_req && d_req) begin
               state_d = (last_q == PORT_D) ? ST_GRANT_I : ST_GRANT_D;
            end else if (d_req) begin
               state_d = ST_GRANT_D;
            end else if (i_req) begin
               state_d = ST_GRANT_I;
            end
         end
         ST_GRANT_I: begin
            if (!own_req || abort) begin
               state_d = ST_IDLE;
            end else if (complete) begin
               last_d  = PORT_I;
               state_d = other_req ? ST_GRANT_D : ST_GRANT_I;
            end
         end
         ST_GRANT_D: begin
            if (!own_req || abort) begin
               state_d = ST_IDLE;
            end else if (complete) begin
               last_d  = PORT_D;
               state_d = other_req ? ST_GRANT_I : ST_GRANT_D;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // Strobes are withheld in the abort cycle so the slave cannot accept a
   // transfer the requester is being told was dropped.
   always_comb begin
      m_address     = '0;
      m_read        = 1'b0;
      m_write       = 1'b0;
      m_writedata   = '0;
      m_byteenable  = '0;
      i_waitrequest = 1'b1;
      d_waitrequest = 1'b1;
      i_readdata    = abort ? 32'h0 : m_readdata;
      d_readdata    = abort ? 32'h0 : m_readdata;
      case (state_q)
         ST_GRANT_I: begin
            m_address     = i_address;
            m_read        = i_read & ~abort;
            m_byteenable  = 4'hF;
            i_waitrequest = abort ? 1'b0 : m_waitrequest;
         end
         ST_GRANT_D: begin
            m_address     = d_address;
            m_read        = d_rd & ~abort;
            m_write       = d_write & ~abort;
            m_writedata   = d_writedata;
            m_byteenable  = d_byteenable;
            d_waitrequest = abort ? 1'b0 : m_waitrequest;
         end
         default: ;
      endcase
   end

   assign timeout_err = timeout_err_q;

endmodule
